// File: rtl/fpu_result_collector.sv
// FP writeback collector: tracks destination tags per FP unit, drives two
// register-file write ports and spills surplus completions into a FIFO.

module fpu_tag_pipe #(
  parameter int LAT = 3,
  parameter int AW  = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_vld,
  input  logic [AW-1:0]              in_dst,
  output logic                       out_vld,
  output logic [AW-1:0]              out_dst,
  output logic [$clog2(LAT+1)-1:0]   n_vld
);
  localparam int NW = $clog2(LAT+1);

  logic [LAT-1:0]         vld_q, vld_d;
  logic [LAT-1:0][AW-1:0] dst_q, dst_d;

  always_comb begin
    vld_d[0] = in_vld;
    dst_d[0] = in_dst;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      dst_d[i] = dst_q[i-1];
    end
    n_vld = '0;
    for (int i = 0; i < LAT; i++) n_vld = n_vld + NW'(vld_q[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      dst_q <= '0;
    end else begin
      vld_q <= vld_d;
      dst_q <= dst_d;
    end
  end

  assign out_vld = vld_q[LAT-1];
  assign out_dst = dst_q[LAT-1];
endmodule

module fpu_result_collector #(
  parameter int         W        = 32,
  parameter int         AW       = 5,
  parameter int         LAT_ADD  = 3,
  parameter int         LAT_MUL  = 4,
  parameter int         DEPTH    = 8,
  parameter logic [2:0] U_TRNS   = 3'd1,
  parameter logic [2:0] U_ADDSUB = 3'd2,
  parameter logic [2:0] U_MUL    = 3'd3,
  parameter logic [2:0] U_DIV    = 3'd4,
  parameter logic [2:0] U_SQRT   = 3'd5,
  parameter logic [2:0] U_ABSOPP = 3'd6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [2:0]                 iss_unit1,
  input  logic [2:0]                 iss_unit2,
  input  logic [AW-1:0]              iss_dst1,
  input  logic [AW-1:0]              iss_dst2,
  output logic                       iss_ready,
  output logic                       div_busy,
  output logic                       sqrt_busy,
  input  logic                       div_done,
  input  logic                       sqrt_done,
  input  logic [W-1:0]               addsub_out,
  input  logic [W-1:0]               mul_out,
  input  logic [W-1:0]               div_out,
  input  logic [W-1:0]               sqrt_out,
  input  logic [W-1:0]               trns_out,
  input  logic [W-1:0]               absopp1_out,
  input  logic [W-1:0]               absopp2_out,
  output logic                       wr_en1,
  output logic                       wr_en2,
  output logic [AW-1:0]              wr_addr1,
  output logic [AW-1:0]              wr_addr2,
  output logic [W-1:0]               wr_data1,
  output logic [W-1:0]               wr_data2,
  output logic [$clog2(DEPTH):0]     fifo_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NC = 6;

  typedef struct packed {
    logic [AW-1:0] dst;
    logic [W-1:0]  data;
  } wb_t;

  // Issue decode
  logic          add_iss, mul_iss, div_iss, sqrt_iss, sh1_iss, sh2_iss;
  logic [AW-1:0] add_dst, mul_dst, div_dst, sqrt_dst;
  logic [W-1:0]  sh1_data, sh2_data;

  always_comb begin
    add_iss  = iss_ready && (iss_unit1 == U_ADDSUB || iss_unit2 == U_ADDSUB);
    mul_iss  = iss_ready && (iss_unit1 == U_MUL    || iss_unit2 == U_MUL);
    div_iss  = iss_ready && (iss_unit1 == U_DIV    || iss_unit2 == U_DIV);
    sqrt_iss = iss_ready && (iss_unit1 == U_SQRT   || iss_unit2 == U_SQRT);
    add_dst  = (iss_unit1 == U_ADDSUB) ? iss_dst1 : iss_dst2;
    mul_dst  = (iss_unit1 == U_MUL)    ? iss_dst1 : iss_dst2;
    div_dst  = (iss_unit1 == U_DIV)    ? iss_dst1 : iss_dst2;
    sqrt_dst = (iss_unit1 == U_SQRT)   ? iss_dst1 : iss_dst2;
    sh1_iss  = iss_ready && (iss_unit1 == U_TRNS || iss_unit1 == U_ABSOPP);
    sh2_iss  = iss_ready && (iss_unit2 == U_TRNS || iss_unit2 == U_ABSOPP);
    sh1_data = (iss_unit1 == U_TRNS) ? trns_out : absopp1_out;
    sh2_data = (iss_unit2 == U_TRNS) ? trns_out : absopp2_out;
  end

  // Fixed-latency tag pipelines
  logic                          add_cmp, mul_cmp;
  logic [AW-1:0]                 add_cdst, mul_cdst;
  logic [$clog2(LAT_ADD+1)-1:0]  add_n;
  logic [$clog2(LAT_MUL+1)-1:0]  mul_n;

  fpu_tag_pipe #(.LAT(LAT_ADD), .AW(AW)) u_add_tags (
    .clk(clk), .rst_n(rst_n), .in_vld(add_iss), .in_dst(add_dst),
    .out_vld(add_cmp), .out_dst(add_cdst), .n_vld(add_n)
  );

  fpu_tag_pipe #(.LAT(LAT_MUL), .AW(AW)) u_mul_tags (
    .clk(clk), .rst_n(rst_n), .in_vld(mul_iss), .in_dst(mul_dst),
    .out_vld(mul_cmp), .out_dst(mul_cdst), .n_vld(mul_n)
  );

  // Iterative unit scoreboards; a strobe with no tag held is dropped
  logic          div_vld_q, div_vld_d, sqrt_vld_q, sqrt_vld_d;
  logic [AW-1:0] div_dst_q, div_dst_d, sqrt_dst_q, sqrt_dst_d;
  logic          div_cmp, sqrt_cmp;

  always_comb begin
    div_cmp    = div_vld_q && div_done;
    sqrt_cmp   = sqrt_vld_q && sqrt_done;
    div_vld_d  = div_vld_q && !div_cmp;
    div_dst_d  = div_dst_q;
    sqrt_vld_d = sqrt_vld_q && !sqrt_cmp;
    sqrt_dst_d = sqrt_dst_q;
    if (div_iss) begin
      div_vld_d = 1'b1;
      div_dst_d = div_dst;
    end
    if (sqrt_iss) begin
      sqrt_vld_d = 1'b1;
      sqrt_dst_d = sqrt_dst;
    end
  end

  assign div_busy  = div_vld_q;
  assign sqrt_busy = sqrt_vld_q;

  // Flow control from registered state only
  logic [CW-1:0] cnt_q, cnt_d;
  int            inflight;

  always_comb begin
    inflight  = int'(add_n) + int'(mul_n) + int'(div_vld_q) + int'(sqrt_vld_q);
    iss_ready = (int'(cnt_q) + inflight) <= (DEPTH - 2);
  end

  // New completions in writeback priority order
  logic [NC-1:0]       nc_vld;
  wb_t  [NC-1:0]       nc_ent;

  always_comb begin
    nc_vld[0] = div_cmp;  nc_ent[0] = {div_dst_q, div_out};
    nc_vld[1] = sqrt_cmp; nc_ent[1] = {sqrt_dst_q, sqrt_out};
    nc_vld[2] = mul_cmp;  nc_ent[2] = {mul_cdst, mul_out};
    nc_vld[3] = add_cmp;  nc_ent[3] = {add_cdst, addsub_out};
    nc_vld[4] = sh1_iss;  nc_ent[4] = {iss_dst1, sh1_data};
    nc_vld[5] = sh2_iss;  nc_ent[5] = {iss_dst2, sh2_data};
  end

  // Arbitration: FIFO oldest-first owns the ports, then new completions;
  // whatever does not reach a port is appended to the FIFO.
  wb_t           mem_q [DEPTH];
  wb_t           mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [1:0]    port_vld;
  wb_t  [1:0]    port_ent;
  int            n_pop, n_push, slot, fill;

  always_comb begin
    mem_d    = mem_q;
    port_vld = '0;
    port_ent = '0;
    n_pop    = (cnt_q >= CW'(2)) ? 2 : int'(cnt_q);
    for (int p = 0; p < 2; p++) begin
      if (p < n_pop) begin
        port_vld[p] = 1'b1;
        port_ent[p] = mem_q[rd_ptr_q + PW'(p)];
      end
    end
    slot   = n_pop;
    n_push = 0;
    for (int i = 0; i < NC; i++) begin
      if (nc_vld[i]) begin
        if (slot == 0) begin
          port_vld[0] = 1'b1;
          port_ent[0] = nc_ent[i];
          slot = 1;
        end else if (slot == 1) begin
          port_vld[1] = 1'b1;
          port_ent[1] = nc_ent[i];
          slot = 2;
        end else begin
          mem_d[wr_ptr_q + PW'(n_push)] = nc_ent[i];
          n_push = n_push + 1;
        end
      end
    end
    fill     = int'(cnt_q) + n_push - n_pop;
    cnt_d    = CW'(fill);
    rd_ptr_d = rd_ptr_q + PW'(n_pop);
    wr_ptr_d = wr_ptr_q + PW'(n_push);
  end

  logic wr_en1_q, wr_en2_q;
  wb_t  p1_q, p2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_vld_q  <= 1'b0;
      div_dst_q  <= '0;
      sqrt_vld_q <= 1'b0;
      sqrt_dst_q <= '0;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      wr_en1_q   <= 1'b0;
      wr_en2_q   <= 1'b0;
      p1_q       <= '0;
      p2_q       <= '0;
    end else begin
      div_vld_q  <= div_vld_d;
      div_dst_q  <= div_dst_d;
      sqrt_vld_q <= sqrt_vld_d;
      sqrt_dst_q <= sqrt_dst_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      wr_en1_q   <= port_vld[0];
      wr_en2_q   <= port_vld[1];
      p1_q       <= port_ent[0];
      p2_q       <= port_ent[1];
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;

  assign wr_en1   = wr_en1_q;
  assign wr_en2   = wr_en2_q;
  assign wr_addr1 = p1_q.dst;
  assign wr_addr2 = p2_q.dst;
  assign wr_data1 = p1_q.data;
  assign wr_data2 = p2_q.data;
  assign fifo_cnt = cnt_q;

  a_fifo_ovf: assert property (@(posedge clk) disable iff (!rst_n) fill <= DEPTH);
  a_dup_unit: assert property (@(posedge clk) disable iff (!rst_n)
    !(iss_ready && iss_unit1 != 3'd0 && iss_unit1 == iss_unit2 && iss_unit1 != U_ABSOPP));
  a_div_busy: assert property (@(posedge clk) disable iff (!rst_n)
    !(iss_ready && (iss_unit1 == U_DIV || iss_unit2 == U_DIV) && div_vld_q));
  a_sqrt_busy: assert property (@(posedge clk) disable iff (!rst_n)
    !(iss_ready && (iss_unit1 == U_SQRT || iss_unit2 == U_SQRT) && sqrt_vld_q));
endmodule

// File: tb/tb_fpu_result_collector.sv
// Directed bench for fpu_result_collector: latency, arbitration order,
// iterative-unit busy, issue throttling and reset flush.

module tb_fpu_result_collector;
  localparam int W = 32, AW = 5;
  localparam logic [2:0] TRNS = 3'd1, ADD = 3'd2, MUL = 3'd3, DIV = 3'd4,
                         SQRT = 3'd5, ABS = 3'd6;

  logic clk = 1'b0, rst_n;
  logic [2:0] iss_unit1, iss_unit2;
  logic [AW-1:0] iss_dst1, iss_dst2;
  logic iss_ready, div_busy, sqrt_busy, div_done, sqrt_done;
  logic [W-1:0] addsub_out, mul_out, div_out, sqrt_out, trns_out, absopp1_out, absopp2_out;
  logic wr_en1, wr_en2;
  logic [AW-1:0] wr_addr1, wr_addr2;
  logic [W-1:0] wr_data1, wr_data2;
  logic [3:0] fifo_cnt;

  fpu_result_collector dut (
    .clk(clk), .rst_n(rst_n),
    .iss_unit1(iss_unit1), .iss_unit2(iss_unit2),
    .iss_dst1(iss_dst1), .iss_dst2(iss_dst2),
    .iss_ready(iss_ready), .div_busy(div_busy), .sqrt_busy(sqrt_busy),
    .div_done(div_done), .sqrt_done(sqrt_done),
    .addsub_out(addsub_out), .mul_out(mul_out), .div_out(div_out),
    .sqrt_out(sqrt_out), .trns_out(trns_out),
    .absopp1_out(absopp1_out), .absopp2_out(absopp2_out),
    .wr_en1(wr_en1), .wr_en2(wr_en2),
    .wr_addr1(wr_addr1), .wr_addr2(wr_addr2),
    .wr_data1(wr_data1), .wr_data2(wr_data2),
    .fifo_cnt(fifo_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    iss_unit1 = '0; iss_unit2 = '0; iss_dst1 = '0; iss_dst2 = '0;
    div_done = 1'b0; sqrt_done = 1'b0;
    addsub_out = 32'hDEAD0001; mul_out = 32'hDEAD0002; div_out = 32'hDEAD0003;
    sqrt_out = 32'hDEAD0004; trns_out = 32'hDEAD0005;
    absopp1_out = 32'hDEAD0006; absopp2_out = 32'hDEAD0007;
  endtask

  // saturation model state
  int add_cap[100], mul_cap[100];
  logic [AW+W-1:0] expq[$];
  logic [AW+W-1:0] e;
  int inflight, exp_cnt, nd, n_acc, n_wr;
  logic m_ready, saw_stall, sh_acc;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle_in();
    rst_n = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    chk("rst_en1", wr_en1, 0);      chk("rst_en2", wr_en2, 0);
    chk("rst_addr1", wr_addr1, 0);  chk("rst_data1", wr_data1, 0);
    chk("rst_div_busy", div_busy, 0); chk("rst_sqrt_busy", sqrt_busy, 0);
    chk("rst_ready", iss_ready, 1); chk("rst_fifo", fifo_cnt, 0);

    // single AddSub, latency 3 + 1 register
    iss_unit1 = ADD; iss_dst1 = 5;
    tick; idle_in();
    chk("add_early", wr_en1, 0);
    tick; tick;
    addsub_out = 32'h3F800000;
    tick; idle_in();
    chk("add_en1", wr_en1, 1); chk("add_addr1", wr_addr1, 5);
    chk("add_data1", wr_data1, 32'h3F800000); chk("add_en2", wr_en2, 0);

    // AbsOpp on both slots
    iss_unit1 = ABS; iss_dst1 = 1; iss_unit2 = ABS; iss_dst2 = 2;
    absopp1_out = 32'hBF800000; absopp2_out = 32'h40000000;
    tick; idle_in();
    chk("abs_en1", wr_en1, 1); chk("abs_addr1", wr_addr1, 1); chk("abs_data1", wr_data1, 32'hBF800000);
    chk("abs_en2", wr_en2, 1); chk("abs_addr2", wr_addr2, 2); chk("abs_data2", wr_data2, 32'h40000000);

    // four completions in one cycle: Div, Mul, AddSub, Trns
    iss_unit1 = DIV; iss_dst1 = 10;
    tick; idle_in();
    iss_unit1 = MUL; iss_dst1 = 11;
    tick; idle_in();
    iss_unit2 = ADD; iss_dst2 = 12;
    tick; idle_in();
    tick; tick;
    div_done = 1'b1; div_out = 32'h11111111; mul_out = 32'h22222222;
    addsub_out = 32'h33333333; iss_unit1 = TRNS; iss_dst1 = 13; trns_out = 32'h44444444;
    tick; idle_in();
    chk("q4_addr1", wr_addr1, 10); chk("q4_data1", wr_data1, 32'h11111111);
    chk("q4_addr2", wr_addr2, 11); chk("q4_data2", wr_data2, 32'h22222222);
    chk("q4_en", {wr_en1, wr_en2}, 2'b11); chk("q4_fifo_peak", fifo_cnt, 2);
    chk("q4_div_idle", div_busy, 0);
    tick;
    chk("q4b_addr1", wr_addr1, 12); chk("q4b_data1", wr_data1, 32'h33333333);
    chk("q4b_addr2", wr_addr2, 13); chk("q4b_data2", wr_data2, 32'h44444444);
    chk("q4b_en", {wr_en1, wr_en2}, 2'b11); chk("q4b_fifo", fifo_cnt, 0);
    tick;
    chk("q4c_en", {wr_en1, wr_en2}, 2'b00);

    // long Div: busy until the cycle after done
    iss_unit1 = DIV; iss_dst1 = 7;
    tick; idle_in();
    for (int i = 0; i < 20; i++) begin
      chk("div_busy_wait", div_busy, 1);
      chk("div_no_wr", wr_en1, 0);
      tick;
    end
    div_done = 1'b1; div_out = 32'h55AA55AA;
    chk("div_busy_done", div_busy, 1);
    tick; idle_in();
    chk("div_busy_fall", div_busy, 0); chk("div_en1", wr_en1, 1);
    chk("div_addr1", wr_addr1, 7); chk("div_data1", wr_data1, 32'h55AA55AA);
    chk("div_en2", wr_en2, 0);
    tick;
    chk("div_once", wr_en1, 0);

    // Sqrt from slot 2
    iss_unit2 = SQRT; iss_dst2 = 9;
    tick; idle_in();
    chk("sqrt_busy", sqrt_busy, 1);
    tick; tick;
    sqrt_done = 1'b1; sqrt_out = 32'h3FB504F3;
    tick; idle_in();
    chk("sqrt_idle", sqrt_busy, 0); chk("sqrt_en1", wr_en1, 1);
    chk("sqrt_addr1", wr_addr1, 9); chk("sqrt_data1", wr_data1, 32'h3FB504F3);
    tick;

    // saturation: write stream must equal capture stream in priority order
    foreach (add_cap[i]) begin add_cap[i] = -1; mul_cap[i] = -1; end
    inflight = 0; nd = 0; n_acc = 0; n_wr = 0; saw_stall = 1'b0;
    for (int k = 0; k < 75; k++) begin
      exp_cnt = (expq.size() > 2) ? expq.size() - 2 : 0;
      chk("sat_fifo_cnt", fifo_cnt, exp_cnt);
      m_ready = (exp_cnt + inflight) <= 6;
      chk("sat_ready", iss_ready, m_ready);
      if (!m_ready) saw_stall = 1'b1;
      chk("sat_en1", wr_en1, expq.size() > 0);
      chk("sat_en2", wr_en2, expq.size() > 1);
      if (wr_en1 && expq.size() > 0) begin
        e = expq.pop_front(); n_wr++;
        chk("sat_w1", {wr_addr1, wr_data1}, e);
      end
      if (wr_en2 && expq.size() > 0) begin
        e = expq.pop_front(); n_wr++;
        chk("sat_w2", {wr_addr2, wr_data2}, e);
      end
      idle_in();
      addsub_out = 32'hA0000000 | k; mul_out = 32'hB0000000 | k;
      absopp1_out = 32'hC0000000 | k; absopp2_out = 32'hD0000000 | k;
      sh_acc = 1'b0;
      if (k < 45) begin
        iss_dst1 = AW'(nd); iss_dst2 = AW'(nd + 1);
        if (k >= 20 && k % 2 == 0) begin
          iss_unit1 = ABS; iss_unit2 = ABS;
          sh_acc = m_ready;
        end else begin
          iss_unit1 = ADD; iss_unit2 = MUL;
          if (m_ready) begin
            add_cap[k+3] = nd; mul_cap[k+4] = (nd + 1) % 32;
            inflight += 2;
          end
        end
        if (m_ready) begin nd = (nd + 2) % 32; n_acc += 2; end
      end
      if (mul_cap[k] >= 0) begin expq.push_back({AW'(mul_cap[k]), 32'hB0000000 | k}); inflight--; end
      if (add_cap[k] >= 0) begin expq.push_back({AW'(add_cap[k]), 32'hA0000000 | k}); inflight--; end
      if (sh_acc) begin
        expq.push_back({iss_dst1, 32'hC0000000 | k});
        expq.push_back({iss_dst2, 32'hD0000000 | k});
      end
      tick;
    end
    idle_in();
    chk("sat_all_written", n_wr, n_acc);
    chk("sat_q_empty", expq.size(), 0);
    chk("sat_stalled", saw_stall, 1);

    // reset flush with three ops in flight
    iss_unit1 = DIV; iss_dst1 = 3; iss_unit2 = ADD; iss_dst2 = 4;
    tick; idle_in();
    iss_unit1 = MUL; iss_dst1 = 6;
    tick; idle_in();
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("flush_ready", iss_ready, 1); chk("flush_fifo", fifo_cnt, 0);
    chk("flush_div_busy", div_busy, 0);
    for (int i = 0; i < 8; i++) begin
      div_done = (i == 2); div_out = 32'h77777777;
      chk("flush_no_wr", {wr_en1, wr_en2}, 2'b00);
      tick;
    end
    idle_in();
    chk("flush_div_busy_end", div_busy, 0);
    chk("flush_ready_end", iss_ready, 1);
    chk("flush_fifo_end", fifo_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
